// File: rtl/mult_share_sched.sv
// Round-robin arbiter sharing one START/READY sequential multiplier
// among NREQ requesters, with a watchdog for a hung multiplier.
module mult_share_sched #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                    CK,
    input  logic                    RST,
    input  logic [NREQ-1:0]         REQ,
    input  logic [NREQ*WIDTH-1:0]   REQ_A,
    input  logic [NREQ*WIDTH-1:0]   REQ_B,
    output logic [NREQ-1:0]         GNT,
    output logic [NREQ-1:0]         DONE,
    output logic                    ERR,
    output logic [2*WIDTH-1:0]      RESULT,
    output logic                    BUSY,
    output logic                    MSTART,
    output logic [WIDTH-1:0]        MA,
    output logic [WIDTH-1:0]        MB,
    input  logic                    MREADY,
    input  logic [2*WIDTH-1:0]      MP
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        ARM,
        RUN,
        RESPOND
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic [NREQ-1:0] win_oh;
    logic [WD_W-1:0] wd;
    logic [WD_W-1:0] wd_inc;
    logic            wd_hit;

    // First set request scanning upward from ptr+1, wrapping.
    always_comb begin
        logic          found;
        logic [PW-1:0] sel;
        found = 1'b0;
        sel   = '0;
        win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            sel = PW'((int'(ptr) + k) % NREQ);
            if (!found && REQ[sel]) begin
                found = 1'b1;
                win   = sel;
            end
        end
        win_oh = NREQ'(1) << win;
    end

    // RESPOND lands TIMEOUT cycles after the LAUNCH cycle.
    always_comb begin
        wd_inc = (wd == WD_W'(TIMEOUT)) ? wd : wd + 1'b1;
        wd_hit = (wd_inc >= WD_W'(TIMEOUT - 1));
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state  <= IDLE;
            ptr    <= PW'(NREQ - 1);
            wd     <= '0;
            GNT    <= '0;
            DONE   <= '0;
            ERR    <= 1'b0;
            RESULT <= '0;
            BUSY   <= 1'b0;
            MSTART <= 1'b0;
            MA     <= '0;
            MB     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if ((|REQ) && MREADY) begin
                        GNT    <= win_oh;
                        MA     <= REQ_A[win*WIDTH +: WIDTH];
                        MB     <= REQ_B[win*WIDTH +: WIDTH];
                        ptr    <= win;
                        MSTART <= 1'b1;
                        BUSY   <= 1'b1;
                        state  <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    MSTART <= 1'b0;
                    wd     <= '0;
                    state  <= ARM;
                end
                ARM: begin
                    wd <= wd_inc;
                    if (!MREADY) begin
                        state <= RUN;
                    end else if (wd_hit) begin
                        DONE   <= GNT;
                        ERR    <= 1'b1;
                        RESULT <= '0;
                        state  <= RESPOND;
                    end
                end
                RUN: begin
                    wd <= wd_inc;
                    if (MREADY) begin
                        DONE   <= GNT;
                        ERR    <= 1'b0;
                        RESULT <= MP;
                        state  <= RESPOND;
                    end else if (wd_hit) begin
                        DONE   <= GNT;
                        ERR    <= 1'b1;
                        RESULT <= '0;
                        state  <= RESPOND;
                    end
                end
                RESPOND: begin
                    DONE  <= '0;
                    ERR   <= 1'b0;
                    GNT   <= '0;
                    MA    <= '0;
                    MB    <= '0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mult_share_sched.md
Name: mult_share_sched

Overview:
- Round-robin scheduler that shares one 4x4 shift-add sequential multiplier (START/READY interface, 8-bit product) among NREQ requesters.
- Grants one requester at a time, drives the multiplier's START and operand buses, and tracks READY through its fall and rise.
- Returns the product with a one-cycle DONE pulse.
- Sits between client logic and the multiplier. A watchdog reports a hung multiplier.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, operand width; product is 2*WIDTH.
- TIMEOUT, 16, maximum cycles from START to READY rising before an error is flagged.

Ports:
- CK  in  1  clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- REQ  in  NREQ  per-requester request level.
- REQ_A  in  NREQ*WIDTH  multiplicand; slice i belongs to requester i.
- REQ_B  in  NREQ*WIDTH  multiplier operand; slice i belongs to requester i.
- GNT  out  NREQ  one-hot grant, held for the whole operation.
- DONE  out  NREQ  one-cycle completion pulse to the granted requester.
- ERR  out  1  one-cycle pulse coincident with DONE when the watchdog fired.
- RESULT  out  2*WIDTH  product; valid in the DONE cycle and held until the next DONE.
- BUSY  out  1  high whenever state is not IDLE.
- MSTART  out  1  START to the multiplier.
- MA  out  WIDTH  A operand to the multiplier.
- MB  out  WIDTH  B operand to the multiplier.
- MREADY  in  1  READY from the multiplier.
- MP  in  2*WIDTH  product P from the multiplier.

Behaviour:
- Reset value of every output is 0. State resets to IDLE. Round-robin pointer resets to NREQ-1, so requester 0 has highest priority first.
- RST mid-operation aborts immediately: no DONE, MSTART drops in the same edge.
- The multiplier has no reset of its own.
- State machine: IDLE -> LAUNCH -> ARM -> RUN -> RESPOND -> IDLE.
- IDLE:
  - Grants only when (|REQ) and MREADY=1. MREADY=0 in IDLE blocks all grants (multiplier still counting after our reset).
  - Winner is the first set REQ at index ptr+1, ptr+2, ... modulo NREQ.
  - On the grant edge: GNT[w]=1; REQ_A/REQ_B slices of w are registered; ptr<=w; go to LAUNCH.
- LAUNCH (exactly 1 cycle): MSTART=1; MA/MB driven from the registered operands; watchdog cleared to 0; go to ARM.
- ARM: MSTART=0. Waits for MREADY=0, then goes to RUN.
- RUN: waits for MREADY=1, then goes to RESPOND.
- MA/MB hold the registered operands from LAUNCH through RESPOND. Live REQ_A/REQ_B changes are ignored after the grant.
- Watchdog:
  - Increments every cycle in ARM and RUN; saturating, width clog2(TIMEOUT+1).
  - Reaching TIMEOUT in ARM or RUN forces RESPOND with the error flag set.
- RESPOND (1 cycle):
  - Normal: RESULT<=MP; DONE[w]=1; ERR=0.
  - Error: RESULT<=0; DONE[w]=1; ERR=1.
  - GNT cleared on exit; back to IDLE.
- Minimum turnaround is 2 IDLE-to-IDLE cycles beyond the multiplier run time.
- A new grant is possible the cycle after RESPOND. The same requester re-wins only if no other REQ is set.
- Requesters must hold REQ until DONE. Dropping REQ mid-operation does not abort: the operation completes and DONE still pulses.
- Requesters must drop REQ in the DONE cycle to avoid an unwanted repeat.
- Simultaneous REQ rising and RESPOND: the new REQ is considered in the following IDLE cycle.
- Invariants: GNT is zero or one-hot; DONE is zero or one-hot, and DONE[i] implies GNT[i] in that cycle; MSTART is high only in LAUNCH.

Test Plan:
- Only REQ[0], A=3, B=5, MREADY modelled by the real multiplier:
  - GNT=0001 at the next edge; MSTART high for exactly 1 cycle; MA=3, MB=5.
  - DONE=0001 with RESULT=15 and ERR=0; BUSY low the cycle after.
- REQ=1111 held, operands (1,2), (3,4), (5,6), (7,8):
  - DONE order is 0,1,2,3 with RESULT=2, 12, 30, 56.
  - Keeping REQ[1]=1 afterwards grants 1 next.
- REQ[2] with A=15, B=15 -> RESULT=225 (0xE1); max-value product, no overflow.
- MREADY forced low after LAUNCH, TIMEOUT=16:
  - DONE[i] and ERR=1 exactly 16 cycles after LAUNCH; RESULT=0; next grant proceeds normally once MREADY=1.
- RST pulsed during RUN:
  - All outputs 0 next edge; no DONE.
  - With MREADY held low after reset, no GNT until MREADY=1; then grant goes to the lowest set REQ index.
- REQ[3] drops in ARM -> operation completes, DONE=1000 still pulses with the correct product.
